reg_bank: RTL
=============

// Module: reg_bank
// PURPOSE
//  32 x 32-bit MIPS general-purpose register file for the multicycle datapath.
//  Sits directly downstream of mux_writereg: its write address is that mux's 5-bit output.
//  Two combinational read ports feed the A/B latches; one synchronous write port is driven by the write-back mux.
//  $0 is hardwired to zero. $sp ($29) comes out of reset at a fixed stack-top value.
// PARAMETERS
//  DATA_W    32          register width in bits
//  ADDR_W    5           address width; depth = 2**ADDR_W
//  SP_IDX    29          index of the stack-pointer register
//  SP_RESET  32'd227     value loaded into register SP_IDX on reset
// PORTS
//  clk        in   1       system clock; all state updates on the rising edge
//  reset_n    in   1       synchronous, active-low reset; sampled on the rising clk edge
//  reg_write  in   1       write enable from the control unit
//  rd_addr_a  in   ADDR_W  read port A address (instr[25:21])
//  rd_addr_b  in   ADDR_W  read port B address (instr[20:16])
//  wr_addr    in   ADDR_W  write address (mux_writereg output)
//  wr_data    in   DATA_W  write data (write-back mux output)
//  rd_data_a  out  DATA_W  read port A data
//  rd_data_b  out  DATA_W  read port B data
// BEHAVIOUR
//  - Reset: clk edge with reset_n==0 sets every register to 0, except reg[SP_IDX], which gets SP_RESET.
//    Reset has priority over reg_write on that edge; a write in progress is dropped.
//  - Write: clk edge with reset_n==1 && reg_write==1 && wr_addr!=0 sets reg[wr_addr] <= wr_data.
//    Takes effect after exactly one edge. reg_write==0 leaves all registers unchanged.
//  - $0: a write to address 0 is ignored. rd_data_x is 0 whenever rd_addr_x==0, regardless of contents.
//  - Read: purely combinational, rd_data_x = reg[rd_addr_x], zero cycles of latency.
//    While reset_n==0 the outputs follow the array; they show the reset values from the edge after reset onwards.
//  - Same address on both ports: both outputs carry the same value.
//  - Read and write to the same address in one cycle: the read returns the OLD value unless
//    REG_BANK_BYPASS_EN is defined (see CONFIGURATION).
//  - All addresses 0..31 are legal. There is no out-of-range case and no X on outputs after reset.
//  - Width rules: no sign handling or truncation; wr_data is stored bit-exact.
// CONFIGURATION
//  REG_BANK_BYPASS_EN defined:
//   - rd_data_x = wr_data when reg_write && reset_n && wr_addr==rd_addr_x && wr_addr!=0.
//   - Same-cycle write-to-read forwarding, combinational.
//  REG_BANK_BYPASS_EN undefined:
//   - No forwarding path. A read in the write cycle sees the pre-write value.
//   - This is the default multicycle timing: the A/B latches load in a different state from write-back.
// STRUCTURE
//  - Shared package cpu_pkg holds: REG_ZERO=5'd0, REG_SP=5'd29, REG_RA=5'd31, SP_RESET_VAL=32'd227, DATA_W, ADDR_W.
//    mux_writereg's constants 29/31 move to the same package.
//  - One sub-module: reg_bank_rdport, instanced twice.
//    It holds the address decode, the $0 zero-forcing and the optional bypass compare for one read port.
//  - The storage array and the write logic stay in reg_bank.
// TESTING
//  1. Reset: hold reset_n=0 for 2 edges, then release.
//     Read all 32 addresses -> reg[29]==227; every other register ==0.
//  2. Write then read: reg_write=1, wr_addr=8, wr_data=32'hDEADBEEF, one edge.
//     Then rd_addr_a=8 -> rd_data_a==32'hDEADBEEF, with zero delay after the edge.
//  3. $0 protection: write 32'hFFFFFFFF to wr_addr=0.
//     rd_addr_a=0, rd_addr_b=0 -> both outputs ==0.
//  4. Same-cycle read/write: reg[5]==1, then write 2 to address 5 with rd_addr_b=5 during the write cycle.
//     Before the edge: rd_data_b==1 without the macro, ==2 with REG_BANK_BYPASS_EN.
//     After the edge: rd_data_b==2 in both builds.
//  5. Reset beats write: reg_write=1, wr_addr=29, wr_data=5, reset_n=0 on the same edge -> reg[29]==227.
//  6. Enable low: reg_write=0, wr_addr=31, wr_data=7 for 3 edges -> reg[31] keeps its previous value (0 after reset).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry, special register indices
// and the stack-top value loaded into $sp at reset. mux_writereg uses
// REG_SP and REG_RA from here as well.
package cpu_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ADDR_W       = 5;

    localparam logic [4:0]  REG_ZERO     = 5'd0;
    localparam logic [4:0]  REG_SP       = 5'd29;
    localparam logic [4:0]  REG_RA       = 5'd31;

    localparam logic [31:0] SP_RESET_VAL = 32'd227;

    // True when an address selects the hardwired-zero register.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_bank_rdport.sv
// One combinational read port of the register bank: selects a word from
// the storage array, forces $0 to read as zero and, when REG_BANK_BYPASS_EN
// is defined, forwards the word being written in the same cycle.
module reg_bank_rdport
    import cpu_pkg::*;
#(
    parameter int unsigned P_DATA_W = 32,
    parameter int unsigned P_ADDR_W = 5
) (
    input  logic [P_ADDR_W-1:0] addr,
    input  logic [P_DATA_W-1:0] regs [2**P_ADDR_W],
`ifdef REG_BANK_BYPASS_EN
    input  logic                fwd_en,
    input  logic [P_ADDR_W-1:0] wr_addr,
    input  logic [P_DATA_W-1:0] wr_data,
`endif
    output logic [P_DATA_W-1:0] data
);

    // Zero-forcing takes priority; forwarding only applies to nonzero addresses.
    always_comb begin
        data = regs[addr];
        if (addr == '0) begin
            data = '0;
        end
`ifdef REG_BANK_BYPASS_EN
        else if (fwd_en && (wr_addr == addr)) begin
            data = wr_data;
        end
`endif
    end

endmodule

// File: rtl/reg_bank.sv
// 32 x 32-bit MIPS general-purpose register file for the multicycle datapath.
// Two combinational read ports, one synchronous write port, $0 hardwired to
// zero, $sp loaded with a stack-top value on synchronous active-low reset.
// Optional macro REG_BANK_BYPASS_EN adds same-cycle write-to-read forwarding.
module reg_bank
    import cpu_pkg::*;
#(
    parameter int unsigned         DATA_W   = cpu_pkg::DATA_W,
    parameter int unsigned         ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned         SP_IDX   = 29,
    parameter logic [DATA_W-1:0]   SP_RESET = SP_RESET_VAL
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Storage: reset has priority over a write on the same edge; $0 never written.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else if (reg_write && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef REG_BANK_BYPASS_EN
    logic fwd_en;

    // Forwarding is only valid for a write that will actually commit.
    always_comb begin
        fwd_en = reg_write && reset_n;
    end
`endif

    reg_bank_rdport #(
        .P_DATA_W (DATA_W),
        .P_ADDR_W (ADDR_W)
    ) u_rdport_a (
        .addr    (rd_addr_a),
        .regs    (regs),
`ifdef REG_BANK_BYPASS_EN
        .fwd_en  (fwd_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .data    (rd_data_a)
    );

    reg_bank_rdport #(
        .P_DATA_W (DATA_W),
        .P_ADDR_W (ADDR_W)
    ) u_rdport_b (
        .addr    (rd_addr_b),
        .regs    (regs),
`ifdef REG_BANK_BYPASS_EN
        .fwd_en  (fwd_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .data    (rd_data_b)
    );

endmodule
